// File: rtl/sdram_ui_responder_pkg.sv
// sdram_ui_responder_pkg: shared state encoding and interface width defaults for the UI responder
package sdram_ui_responder_pkg;
  localparam int UI_ADDR_WIDTH = 23;
  localparam int UI_DATA_WIDTH = 128;
  typedef enum logic [2:0] {IDLE, WRITE, READ, REFRESH, GAP} state_t;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    return m > c ? m : c;
  endfunction
endpackage

// File: rtl/sdram_ui_responder_ram.sv
// ui_resp_ram: single-port block RAM, synchronous write, registered read, array not reset
module ui_resp_ram #(
  parameter int DEPTH_LOG2 = 8,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  sys_clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] q
);
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
  // write on demand, read every cycle with one cycle of latency
  always_ff @(posedge sys_clk) begin
    if (we) mem[addr] <= wdata;
    q <= mem[addr];
  end
endmodule

// File: rtl/sdram_ui_responder.sv
// sdram_ui_responder: BRAM-backed stand-in for the SDRAM controller user interface
module sdram_ui_responder
  import sdram_ui_responder_pkg::*;
#(
  parameter int ADDR_WIDTH     = UI_ADDR_WIDTH,
  parameter int DATA_WIDTH     = UI_DATA_WIDTH,
  parameter int DEPTH_LOG2     = 8,
  parameter int WR_LATENCY     = 6,
  parameter int RD_LATENCY     = 8,
  parameter int REFRESH_PERIOD = 750,
  parameter int REFRESH_CYCLES = 10
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_enable,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_enable,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_ready,
  output logic                  busy,
  output logic                  alias_err
);
  localparam int LW = $clog2(max3(WR_LATENCY, RD_LATENCY, REFRESH_CYCLES) + 1);
  localparam int RW = $clog2(REFRESH_PERIOD);

  state_t                state, state_nx;
  logic [LW-1:0]         lat_cnt, lat_nx;
  logic [RW-1:0]         ref_cnt;
  logic                  ref_pend, ref_tc;
  logic                  acc_ref, acc_wr, acc_rd, done, rd_last, ram_we;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DEPTH_LOG2-1:0] idx;
  logic [DATA_WIDTH-1:0] wdata, ram_q;
  logic                  unused_low_bits;

  assign ref_tc          = ref_cnt == RW'(REFRESH_PERIOD - 1);
  assign acc_ref         = state == IDLE && ref_pend;
  assign acc_wr          = state == IDLE && !ref_pend && wr_enable;
  assign acc_rd          = state == IDLE && !ref_pend && !wr_enable && rd_enable;
  assign done            = lat_cnt == '0;
  assign rd_last         = state == READ && done;
  assign ram_we          = state == WRITE && done;
  assign addr_sel        = acc_wr ? wr_addr : rd_addr;
  assign unused_low_bits = ^addr_sel[2:0];
  assign busy            = state inside {WRITE, READ, REFRESH};

  // next-state and latency reload; refresh wins over write, write over read
  always_comb begin
    state_nx = state;
    lat_nx   = lat_cnt - 1'b1;
    case (state)
      IDLE: begin
        state_nx = acc_ref ? REFRESH : acc_wr ? WRITE : acc_rd ? READ : IDLE;
        lat_nx   = acc_ref ? LW'(REFRESH_CYCLES - 1) : acc_wr ? LW'(WR_LATENCY - 1) : LW'(RD_LATENCY - 2);
      end
      WRITE, READ, REFRESH: state_nx = done ? GAP : state;
      default: state_nx = IDLE;
    endcase
  end

  // state register and latency counter
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= '0;
    end else begin
      state   <= state_nx;
      lat_cnt <= lat_nx;
    end
  end

  // free-running refresh timer; a terminal count while still pending is dropped
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      ref_cnt  <= '0;
      ref_pend <= 1'b0;
    end else begin
      ref_cnt  <= ref_tc ? '0 : ref_cnt + 1'b1;
      ref_pend <= ref_tc || (ref_pend && !acc_ref);
    end
  end

  // latch command address/data on accept and flag addresses that alias
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      wdata     <= '0;
      alias_err <= 1'b0;
    end else begin
      if (acc_wr || acc_rd) begin
        idx       <= addr_sel[DEPTH_LOG2+2:3];
        alias_err <= alias_err || (|addr_sel[ADDR_WIDTH-1:DEPTH_LOG2+3]);
      end
      if (acc_wr) wdata <= wr_data;
    end
  end

  // read completion: capture the word and pulse rd_ready as busy drops
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rd_ready <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_ready <= rd_last;
      if (rd_last) rd_data <= ram_q;
    end
  end

  ui_resp_ram #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .sys_clk(sys_clk),
    .we     (ram_we),
    .addr   (idx),
    .wdata  (wdata),
    .q      (ram_q)
  );
endmodule
